// File: rtl/rom_arbiter.sv
// Two-port arbiter in front of a combinational word ROM with a 1-cycle registered response.
// ROM_ARB_RR_EN selects round-robin contention; default build gives port 0 fixed priority.
module rom_arbiter #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned ROM_BYTES  = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0,
  input  logic                  req1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  rvalid0,
  output logic                  rvalid1,
  output logic [31:0]           rdata0,
  output logic [31:0]           rdata1,
  output logic                  err0,
  output logic                  err1,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [31:0]           rom_data
);

`ifdef ROM_ARB_RR_EN
  localparam bit RrEn = 1'b1;
`else
  localparam bit RrEn = 1'b0;
`endif

  // Highest legal word start address; anything above it is flagged, no wrap-around.
  localparam logic [ADDR_WIDTH-1:0] MaxAddr = ADDR_WIDTH'(ROM_BYTES - 4);

  logic        last_q, last_d;
  logic        rvalid0_q, rvalid1_q;
  logic [31:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic        err0_q, err0_d, err1_q, err1_d;
  logic        out_of_range;
  logic [31:0] word;

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst) begin
      if (req0 && req1) begin
        // Fixed priority ignores last; round-robin hands the win to the other port.
        gnt0 = !RrEn || last_q;
        gnt1 = !gnt0;
      end else begin
        gnt0 = req0;
        gnt1 = req1;
      end
    end
  end

  assign rom_addr     = gnt1 ? addr1 : addr0;
  assign out_of_range = rom_addr > MaxAddr;
  assign word         = out_of_range ? 32'h0 : rom_data;

  always_comb begin
    last_d   = last_q;
    rdata0_d = rdata0_q;
    err0_d   = err0_q;
    rdata1_d = rdata1_q;
    err1_d   = err1_q;
    if (gnt0) begin
      last_d   = 1'b0;
      rdata0_d = word;
      err0_d   = out_of_range;
    end
    if (gnt1) begin
      last_d   = 1'b1;
      rdata1_d = word;
      err1_d   = out_of_range;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q    <= 1'b1;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata0_q  <= 32'h0;
      rdata1_q  <= 32'h0;
      err0_q    <= 1'b0;
      err1_q    <= 1'b0;
    end else begin
      last_q    <= last_d;
      rvalid0_q <= gnt0;
      rvalid1_q <= gnt1;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
      err0_q    <= err0_d;
      err1_q    <= err1_d;
    end
  end

  assign rvalid0 = rvalid0_q;
  assign rvalid1 = rvalid1_q;
  assign rdata0  = rdata0_q;
  assign rdata1  = rdata1_q;
  assign err0    = err0_q;
  assign err1    = err1_q;

endmodule

// File: tb/tb_rom_arbiter.sv
// Randomised bench for rom_arbiter against a transaction-level model; honours ROM_ARB_RR_EN.
module tb_rom_arbiter;

`ifdef ROM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, req0, req1;
  logic [31:0] addr0, addr1, rom_addr;
  logic [31:0] rom_data, rdata0, rdata1;
  logic        gnt0, gnt1, rvalid0, rvalid1, err0, err1;
  logic [7:0]  mem [256];

  int n_vec = 0;
  int n_fail = 0;

  // Model state: what the registered outputs must read, and who won last.
  logic        m_last;
  logic        e_rv0, e_rv1, e_er0, e_er1;
  logic [31:0] e_rd0, e_rd1;
  logic        obs_g0, obs_g1;

  rom_arbiter #(.ADDR_WIDTH(32), .ROM_BYTES(256)) dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1), .err0(err0), .err1(err1),
    .rom_addr(rom_addr), .rom_data(rom_data)
  );

  always #5 clk = ~clk;

  // Out-of-range reads return garbage so the DUT must zero them itself.
  always_comb begin
    if (rom_addr <= 32'd252)
      rom_data = {mem[rom_addr[7:0] + 8'd3], mem[rom_addr[7:0] + 8'd2],
                  mem[rom_addr[7:0] + 8'd1], mem[rom_addr[7:0]]};
    else
      rom_data = 32'hA5A5_5A5A;
  end

  function automatic logic [31:0] exp_word(input logic [31:0] a);
    int i;
    if (a > 32'd252) return 32'h0;
    i = int'(a[7:0]);
    return {mem[i+3], mem[i+2], mem[i+1], mem[i]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: compare everything mid-cycle, then advance the model across the edge.
  task automatic step();
    logic eg0, eg1, n_last, n_rv0, n_rv1, n_er0, n_er1;
    logic [31:0] n_rd0, n_rd1;
    @(negedge clk);
    eg0 = 1'b0;
    eg1 = 1'b0;
    if (!rst) begin
      if (req0 && req1) begin
        if (RR && !m_last) eg1 = 1'b1;
        else eg0 = 1'b1;
      end else begin
        eg0 = req0;
        eg1 = req1;
      end
    end
    chk("gnt0", 32'(gnt0), 32'(eg0));
    chk("gnt1", 32'(gnt1), 32'(eg1));
    chk("one_hot_gnt", 32'(gnt0 & gnt1), 32'd0);
    chk("rom_addr", rom_addr, eg1 ? addr1 : addr0);
    chk("rvalid0", 32'(rvalid0), 32'(e_rv0));
    chk("rvalid1", 32'(rvalid1), 32'(e_rv1));
    chk("rdata0", rdata0, e_rd0);
    chk("rdata1", rdata1, e_rd1);
    chk("err0", 32'(err0), 32'(e_er0));
    chk("err1", 32'(err1), 32'(e_er1));
    obs_g0 = gnt0;
    obs_g1 = gnt1;
    n_last = m_last; n_rv0 = eg0; n_rv1 = eg1;
    n_rd0 = e_rd0; n_er0 = e_er0; n_rd1 = e_rd1; n_er1 = e_er1;
    if (eg0) begin n_rd0 = exp_word(addr0); n_er0 = addr0 > 32'd252; n_last = 1'b0; end
    if (eg1) begin n_rd1 = exp_word(addr1); n_er1 = addr1 > 32'd252; n_last = 1'b1; end
    if (rst) begin
      n_last = 1'b1; n_rv0 = 1'b0; n_rv1 = 1'b0;
      n_rd0 = 32'h0; n_rd1 = 32'h0; n_er0 = 1'b0; n_er1 = 1'b0;
    end
    @(posedge clk);
    #1;
    m_last = n_last; e_rv0 = n_rv0; e_rv1 = n_rv1;
    e_rd0 = n_rd0; e_rd1 = n_rd1; e_er0 = n_er0; e_er1 = n_er1;
  endtask

  initial begin
    logic [3:0] gpat, vpat;
    logic       pend0, pend1;
    logic [31:0] held;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[0] = 8'h13; mem[1] = 8'h05; mem[2] = 8'h10; mem[3] = 8'h00;
    m_last = 1'b1; e_rv0 = 1'b0; e_rv1 = 1'b0; e_er0 = 1'b0; e_er1 = 1'b0;
    e_rd0 = 32'h0; e_rd1 = 32'h0;
    rst = 1'b1; req0 = 1'b0; req1 = 1'b1; addr0 = 32'h0; addr1 = 32'h20;
    step(); step();
    chk("reset_rvalid1", 32'(rvalid1), 32'd0);
    chk("reset_rdata0", rdata0, 32'h0);

    // Single fetch from word 0.
    rst = 1'b0; req1 = 1'b0; req0 = 1'b1; addr0 = 32'h0;
    step();
    chk("fetch_gnt0", 32'(obs_g0), 32'd1);
    chk("fetch_rvalid0", 32'(rvalid0), 32'd1);
    chk("fetch_rdata0", rdata0, 32'h0010_0513);
    chk("fetch_err0", 32'(err0), 32'd0);

    // Sustained contention straight out of reset.
    req0 = 1'b0;
    rst = 1'b1; step();
    rst = 1'b0; req0 = 1'b1; req1 = 1'b1; addr0 = 32'h4; addr1 = 32'h8;
    for (int i = 0; i < 4; i++) begin
      step();
      gpat[i] = obs_g0;
      vpat[i] = rvalid0;
    end
    chk("contention_gnt0_pattern", 32'(gpat), RR ? 32'h5 : 32'hF);
    chk("contention_rvalid0_pattern", 32'(vpat), RR ? 32'h5 : 32'hF);
    req0 = 1'b0; req1 = 1'b0;
    step();

    // Boundary addresses on port 1.
    req1 = 1'b1; addr1 = 32'hFD;
    step();
    chk("oor_gnt1", 32'(obs_g1), 32'd1);
    chk("oor_err1", 32'(err1), 32'd1);
    chk("oor_rdata1", rdata1, 32'h0);
    addr1 = 32'hFC;
    step();
    chk("edge_err1", 32'(err1), 32'd0);
    chk("edge_rdata1", rdata1, {mem[255], mem[254], mem[253], mem[252]});
    held = rdata1;
    req1 = 1'b0;
    step();
    chk("hold_rvalid1", 32'(rvalid1), 32'd0);
    chk("hold_rdata1", rdata1, held);

    // Reset in the grant cycle kills the response; first contention goes to port 0.
    req1 = 1'b1; addr1 = 32'h10; rst = 1'b1;
    step();
    chk("rst_rvalid1", 32'(rvalid1), 32'd0);
    chk("rst_outputs", {rdata0 | rdata1}, 32'h0);
    rst = 1'b0; req0 = 1'b1; addr0 = 32'h8;
    step();
    chk("post_rst_winner", 32'(obs_g0), 32'd1);
    req0 = 1'b0; req1 = 1'b0;
    step();

    // Random traffic; a waiting requester keeps its request and address.
    pend0 = 1'b0; pend1 = 1'b0;
    for (int c = 0; c < 10000; c++) begin
      rst = ($urandom_range(99) == 0);
      if (!pend0) begin
        req0 = $urandom_range(2) != 0;
        addr0 = ($urandom_range(9) == 0) ? $urandom : 32'($urandom_range(255));
      end
      if (!pend1) begin
        req1 = $urandom_range(2) != 0;
        addr1 = ($urandom_range(9) == 0) ? $urandom : 32'($urandom_range(255));
      end
      step();
      pend0 = req0 && !obs_g0;
      pend1 = req1 && !obs_g1;
    end
    rst = 1'b0; req0 = 1'b0; req1 = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
